// File: rtl/jtag_uart_wb_host_if.sv
// Bundles the Wishbone master port toward the JTAG UART slave and the two byte streams.
// master modport is the host's view; slave modport is the view of whatever sits opposite.
interface jtag_uart_wb_host_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        woverflow_o;
    logic        err_timeout;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready,
        output woverflow_o, err_timeout
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready,
        input  woverflow_o, err_timeout
    );
endinterface

// File: rtl/jtag_uart_wb_host.sv
// Wishbone master turning the JTAG UART data/control registers into TX/RX byte streams.
// Optional ack-timeout abort is enabled by defining JTAG_UART_HOST_TIMEOUT_EN.
module jtag_uart_wb_host #(
    parameter int unsigned POLL_INTERVAL = 64,
    parameter int unsigned TIMEOUT       = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    jtag_uart_wb_host_if.master bus
);
    typedef enum logic [2:0] {StInit, StIdle, StRdCtrl, StWrData, StRdData, StGap} state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d, adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        init_done_q, init_done_d, tx_en_q;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_data_q;
    logic [6:0]  wspace_q, wspace_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        ravail_nz_q, ravail_nz_d, ctrl_ok_q, ctrl_ok_d;
    logic [15:0] poll_q, poll_d;
    logic        wovf_q, wovf_d, err_q, err_d;
    logic        in_bus, ack, abort, tx_accept;

    assign in_bus    = state_q inside {StInit, StRdCtrl, StWrData, StRdData};
    // cyc is only ever high inside a bus state, so stray acks elsewhere fall out here
    assign ack       = cyc_q & bus.wb_ack_i;
    assign tx_accept = bus.tx_valid & bus.tx_ready;

`ifdef JTAG_UART_HOST_TIMEOUT_EN
    logic [15:0] wait_q;
    assign abort = cyc_q & ~bus.wb_ack_i & (wait_q == 16'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wait_q <= '0;
        else if (!cyc_q || ack || abort) wait_q <= '0;
        else                            wait_q <= wait_q + 16'd1;
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;  cyc_d = cyc_q;  we_d = we_q;  adr_d = adr_q;  dat_d = dat_q;
        init_done_d = init_done_q;  hold_valid_d = hold_valid_q;  wspace_d = wspace_q;
        rx_valid_d = rx_valid_q;  rx_data_d = rx_data_q;  ravail_nz_d = ravail_nz_q;
        ctrl_ok_d = ctrl_ok_q;  poll_d = poll_q;  wovf_d = wovf_q;  err_d = 1'b0;

        if (!in_bus && poll_q != 16'd0) poll_d = poll_q - 16'd1;
        if (poll_q == 16'd0)            ctrl_ok_d = 1'b1;
        if (tx_accept)                  hold_valid_d = 1'b1;
        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        if (ack && !we_q)               wovf_d = wovf_q | bus.wb_dat_i[14];
        if (ack || abort) begin
            state_d = StGap;  cyc_d = 1'b0;  we_d = 1'b0;  adr_d = 1'b0;  dat_d = '0;
            err_d   = abort;
        end

        unique case (state_q)
            StInit: begin
                // INIT is always entered with the bus idle; raise the request here
                if (!cyc_q) begin
                    cyc_d = 1'b1;  we_d = 1'b1;  adr_d = 1'b1;  dat_d = 32'h0000_0400;
                end else if (ack) begin
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (hold_valid_q && wspace_q != 7'd0) begin
                    state_d = StWrData;  cyc_d = 1'b1;  we_d = 1'b1;  adr_d = 1'b0;
                    dat_d   = {24'h0, hold_data_q};
                end else if (hold_valid_q && ctrl_ok_q) begin
                    state_d = StRdCtrl;  cyc_d = 1'b1;  we_d = 1'b0;  adr_d = 1'b1;
                end else if (!rx_valid_q && (ravail_nz_q || poll_q == 16'd0)) begin
                    state_d = StRdData;  cyc_d = 1'b1;  we_d = 1'b0;  adr_d = 1'b0;
                end
            end
            StRdCtrl: begin
                if (ack) begin
                    wspace_d = bus.wb_dat_i[22:16];
                    // A full FIFO backs off control polling for one poll interval
                    if (bus.wb_dat_i[22:16] == 7'd0) begin
                        ctrl_ok_d = 1'b0;
                        poll_d    = 16'(POLL_INTERVAL);
                    end
                end
            end
            StWrData: begin
                if (ack) begin
                    wspace_d     = wspace_q - 7'd1;
                    hold_valid_d = 1'b0;
                end
            end
            StRdData: begin
                if (ack) begin
                    ravail_nz_d = |bus.wb_dat_i[22:16];
                    if (bus.wb_dat_i[15]) begin
                        rx_data_d  = bus.wb_dat_i[7:0];
                        rx_valid_d = 1'b1;
                    end else begin
                        poll_d = 16'(POLL_INTERVAL);
                    end
                end
            end
            StGap:   state_d = init_done_q ? StIdle : StInit;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;  cyc_q <= 1'b0;  we_q <= 1'b0;  adr_q <= 1'b0;  dat_q <= '0;
            init_done_q <= 1'b0;  tx_en_q <= 1'b0;  hold_valid_q <= 1'b0;  hold_data_q <= '0;
            wspace_q <= '0;  rx_valid_q <= 1'b0;  rx_data_q <= '0;  ravail_nz_q <= 1'b0;
            ctrl_ok_q <= 1'b1;  poll_q <= '0;  wovf_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;  cyc_q <= cyc_d;  we_q <= we_d;  adr_q <= adr_d;  dat_q <= dat_d;
            init_done_q  <= init_done_d;
            tx_en_q      <= tx_en_q | (state_q == StGap && init_done_q);
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= tx_accept ? bus.tx_data : hold_data_q;
            wspace_q <= wspace_d;  rx_valid_q <= rx_valid_d;  rx_data_q <= rx_data_d;
            ravail_nz_q <= ravail_nz_d;  ctrl_ok_q <= ctrl_ok_d;  poll_q <= poll_d;
            wovf_q <= wovf_d;  err_q <= err_d;
        end
    end

    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.tx_ready    = ~hold_valid_q & tx_en_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.woverflow_o = wovf_q;
    assign bus.err_timeout = err_q;
endmodule
